// File: rtl/led_panel_pkg.sv
// Shared defaults, width helper and state type for the LED panel frame buffer.
package led_panel_pkg;

  localparam int DEFAULT_CHANNELS     = 3;
  localparam int DEFAULT_CHANNEL_BITS = 8;

  function automatic int data_lines(input int channels, input int channel_bits);
    return channels * channel_bits;
  endfunction

  localparam int DEFAULT_DATA_LINES = data_lines(DEFAULT_CHANNELS, DEFAULT_CHANNEL_BITS);
  localparam logic [DEFAULT_DATA_LINES-1:0] DEFAULT_CLEAR_VALUE = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/led_panel_bank_ram.sv
// Two-bank pixel store: channel-masked write port, one read port with a
// one- or two-stage output pipeline that flags valid data.
module led_panel_bank_ram
  import led_panel_pkg::*;
#(
  parameter int ADDR_LINES   = 10,
  parameter int CHANNELS     = DEFAULT_CHANNELS,
  parameter int CHANNEL_BITS = DEFAULT_CHANNEL_BITS,
  parameter int READ_LATENCY = 1,
  localparam int DATA_LINES  = data_lines(CHANNELS, CHANNEL_BITS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_enable,
  input  logic                  wr_bank,
  input  logic [ADDR_LINES-1:0] wr_address,
  input  logic [DATA_LINES-1:0] wr_data,
  input  logic [CHANNELS-1:0]   wr_channel_en,
  input  logic                  rd_enable,
  input  logic                  rd_bank,
  input  logic [ADDR_LINES-1:0] rd_address,
  output logic [DATA_LINES-1:0] rd_data,
  output logic                  rd_valid
);

  logic [DATA_LINES-1:0] mem [2**(ADDR_LINES+1)];
  logic [DATA_LINES-1:0] stage_data;
  logic                  stage_valid;

  // Storage is deliberately not reset; only the read pipeline is.
  always_ff @(posedge clock) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (wr_enable && wr_channel_en[k])
        mem[{wr_bank, wr_address}][k*CHANNEL_BITS +: CHANNEL_BITS] <=
          wr_data[k*CHANNEL_BITS +: CHANNEL_BITS];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_latency2
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          stage_data  <= '0;
          stage_valid <= 1'b0;
        end else begin
          stage_valid <= rd_enable;
          if (rd_enable)
            stage_data <= mem[{rd_bank, rd_address}];
        end
      end
    end else begin : g_latency1
      assign stage_valid = rd_enable;
      assign stage_data  = mem[{rd_bank, rd_address}];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= stage_valid;
      if (stage_valid)
        rd_data <= stage_data;
    end
  end

endmodule

// File: rtl/led_panel_frame_buffer.sv
// Double-buffered LED panel frame memory: bank select, frame-aligned swap,
// and a clear engine that fills the back bank with a constant colour.
module led_panel_frame_buffer
  import led_panel_pkg::*;
#(
  parameter int ADDR_LINES   = 10,
  parameter int CHANNELS     = DEFAULT_CHANNELS,
  parameter int CHANNEL_BITS = DEFAULT_CHANNEL_BITS,
  parameter int READ_LATENCY = 1,
  localparam int DATA_LINES  = data_lines(CHANNELS, CHANNEL_BITS),
  parameter logic [DATA_LINES-1:0] CLEAR_VALUE = DEFAULT_CLEAR_VALUE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_LINES-1:0] wr_address,
  input  logic [DATA_LINES-1:0] wr_data,
  input  logic                  wr_enable,
  input  logic [CHANNELS-1:0]   wr_channel_en,
  output logic                  wr_dropped,
  input  logic [ADDR_LINES-1:0] rd_address,
  input  logic                  rd_enable,
  output logic [DATA_LINES-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  frame_start,
  input  logic                  swap_request,
  output logic                  swap_pending,
  output logic                  front_bank,
  input  logic                  clear_request,
  output logic                  busy,
  output logic                  clear_done
);

  fb_state_t             state, state_next;
  logic [ADDR_LINES-1:0] clear_count;
  logic                  swap_now;
  logic                  eff_front;

  logic                  ram_wr_enable;
  logic                  ram_wr_bank;
  logic [ADDR_LINES-1:0] ram_wr_address;
  logic [DATA_LINES-1:0] ram_wr_data;
  logic [CHANNELS-1:0]   ram_wr_channel_en;

  // The swap takes effect combinationally so a read in the swap cycle already sees the new frame.
  assign swap_now  = frame_start && swap_pending && (state == IDLE);
  assign eff_front = front_bank ^ swap_now;
  assign busy      = (state == CLEAR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next        = state;
    ram_wr_enable     = wr_enable;
    ram_wr_bank       = ~eff_front;
    ram_wr_address    = wr_address;
    ram_wr_data       = wr_data;
    ram_wr_channel_en = wr_channel_en;
    case (state)
      IDLE: begin
        if (clear_request)
          state_next = CLEAR;
      end
      CLEAR: begin
        ram_wr_enable     = 1'b1;
        ram_wr_bank       = ~front_bank;
        ram_wr_address    = clear_count;
        ram_wr_data       = CLEAR_VALUE;
        ram_wr_channel_en = '1;
        if (clear_count == '1)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clear_count  <= '0;
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
      clear_done   <= 1'b0;
      wr_dropped   <= 1'b0;
    end else begin
      front_bank <= eff_front;
      if (swap_now)
        swap_pending <= 1'b0;
      else if (swap_request)
        swap_pending <= 1'b1;
      clear_count <= busy ? clear_count + ADDR_LINES'(1) : '0;
      clear_done  <= busy && (clear_count == '1);
      wr_dropped  <= busy && wr_enable;
    end
  end

  led_panel_bank_ram #(
    .ADDR_LINES   (ADDR_LINES),
    .CHANNELS     (CHANNELS),
    .CHANNEL_BITS (CHANNEL_BITS),
    .READ_LATENCY (READ_LATENCY)
  ) u_bank_ram (
    .clock         (clock),
    .reset_n       (reset_n),
    .wr_enable     (ram_wr_enable),
    .wr_bank       (ram_wr_bank),
    .wr_address    (ram_wr_address),
    .wr_data       (ram_wr_data),
    .wr_channel_en (ram_wr_channel_en),
    .rd_enable     (rd_enable),
    .rd_bank       (eff_front),
    .rd_address    (rd_address),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid)
  );

endmodule

// File: doc/led_panel_frame_buffer.md
Name: led_panel_frame_buffer

Overview:
Double-buffered, channel-maskable frame memory for the LED panel path. The bus-side writer fills the back bank while the panel scanner reads the front bank. Banks swap only on a scanner frame boundary, so the scanner never sees a partially drawn frame. A built-in clear engine fills the back bank with a constant colour.

Parameters:
ADDR_LINES, 10, address width per bank (2^ADDR_LINES pixels per bank)
CHANNELS, 3, colour channels per pixel
CHANNEL_BITS, 8, bits per channel; DATA_LINES = CHANNELS*CHANNEL_BITS (derived, not overridable)
READ_LATENCY, 1, cycles from rd_enable to rd_valid; legal values 1 or 2
CLEAR_VALUE, 0, DATA_LINES-wide word written by the clear engine

Ports:
clock  in  1  single clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
wr_address  in  ADDR_LINES  back-bank write address
wr_data  in  DATA_LINES  write data; channel k occupies bits [k*CHANNEL_BITS +: CHANNEL_BITS]
wr_enable  in  1  write strobe
wr_channel_en  in  CHANNELS  per-channel write mask
wr_dropped  out  1  one-cycle pulse: a write was discarded because busy
rd_address  in  ADDR_LINES  front-bank read address
rd_enable  in  1  read strobe
rd_data  out  DATA_LINES  read data
rd_valid  out  1  rd_data is valid this cycle
frame_start  in  1  scanner pulse at frame boundary
swap_request  in  1  pulse: request bank swap at next frame_start
swap_pending  out  1  swap requested, not yet taken
front_bank  out  1  bank currently read by scanner
clear_request  in  1  pulse: start clearing back bank
busy  out  1  clear engine active
clear_done  out  1  one-cycle pulse after last clear write

Behaviour:
- Reset (reset_n low, async): rd_data=0, rd_valid=0, front_bank=0, swap_pending=0, busy=0, clear_done=0, wr_dropped=0, state=IDLE, clear counter=0, read pipeline flushed. Memory contents are not reset. Reset mid-clear aborts the clear; the back bank is left partially cleared.
- Storage: 2*2^ADDR_LINES words. Physical address = {bank, address}.
- Effective bank: swap_now = frame_start & swap_pending & (state==IDLE). eff_front = front_bank ^ swap_now. At that edge: front_bank <= eff_front and swap_pending <= 0.
- Reads: use bank eff_front, so a read issued in the swap cycle already sees the new frame. rd_data updates and rd_valid=1 exactly READ_LATENCY cycles after a cycle with rd_enable=1. Otherwise rd_valid=0 and rd_data holds its last value. Reads are allowed in every state.
- Writes: go to bank ~eff_front. Only channels with wr_channel_en[k]=1 are updated; wr_channel_en=0 is a no-op. Reads and writes never target the same bank in one cycle, so there is no read-during-write hazard.
- swap_request: sets swap_pending. A request while already pending has no further effect. swap_request together with frame_start and no pending swap only sets pending; the swap happens at the next frame_start.
- FSM:
  - IDLE -> CLEAR on clear_request. Counter starts at 0.
  - CLEAR: each cycle writes CLEAR_VALUE to {~front_bank, counter} with all channels enabled, then counter++. After writing address 2^ADDR_LINES-1: -> IDLE, clear_done pulses in the cycle after that last write. busy=1 while in CLEAR, so clearing takes exactly 2^ADDR_LINES cycles.
  - In CLEAR: wr_enable is discarded and wr_dropped pulses on the next cycle. clear_request is ignored. swap_request still sets pending. frame_start does not swap (front_bank is frozen during CLEAR); the swap waits for the first frame_start back in IDLE.
- Address wrap: none needed; addresses are exact-width.

Decomposition:
- Package led_panel_pkg holds: CHANNELS and CHANNEL_BITS defaults, the DATA_LINES derivation function, the FSM state enum (IDLE, CLEAR), and the CLEAR_VALUE default.
- Sub-module led_panel_bank_ram holds the dual-bank storage: one write port with per-channel enables, one read port, and the READ_LATENCY output pipeline with valid. The top level owns the bank select, swap logic, FSM and clear counter.

Test Plan (ADDR_LINES=4, CHANNELS=3, CHANNEL_BITS=8, READ_LATENCY=1 unless noted):
- Write 0x112233 to addr 5 (mask 111), then swap_request, frame_start, read addr 5 -> rd_data=0x112233 and rd_valid 1 cycle after rd_enable; front_bank=1.
- Masked write: addr 5 holds 0xAABBCC in back bank; write 0x000000 with mask 010 -> after swap, read gives 0xAA00CC.
- Swap timing: swap_request with no frame_start -> swap_pending=1, front_bank unchanged for 10 cycles. Next frame_start plus same-cycle read -> data comes from new bank, swap_pending=0.
- Clear: CLEAR_VALUE=0x0F0F0F, clear_request -> busy for 16 cycles, then clear_done pulse. A wr_enable at cycle 3 of the clear -> wr_dropped pulse and no memory change. After swap, all 16 addresses read 0x0F0F0F.
- Swap during clear: swap_request and frame_start at cycle 2 of the clear -> front_bank unchanged, swap_pending stays 1. First frame_start after busy falls performs the swap.
- READ_LATENCY=2 plus reset: back-to-back reads -> rd_valid 2 cycles later for each read. Assert reset_n low mid-clear -> all outputs at reset values immediately (async). After release, state IDLE and front_bank=0.
